mac_accumulator: RTL and testbench

- Sequential multiply-accumulate (dot-product) stage built around the combinational 8-bit unsigned multiplier.
- Accepts a stream of operand pairs over a valid/ready handshake and registers each 16-bit product.
- Accumulates products into a wide sum; the in_last beat ends a vector.
- Presents the finished sum, term count and overflow flag on an output handshake; holds them until the result is consumed.

---
 rtl/mac_accumulator_pkg.sv | 17 +
 rtl/mac_accumulator_if.sv | 32 +++
 rtl/mac_accumulator_mult.sv | 13 +
 rtl/mac_accumulator.sv | 111 +++++++++++
 tb/tb_mac_accumulator.sv | 201 ++++++++++++++++++++
 5 files changed

// File: rtl/mac_accumulator_pkg.sv
// mac_pkg: shared widths, FSM encoding and limits
// for the multiply-accumulate stage.
package mac_pkg;

  localparam int WIDTH     = 8;
  localparam int ACC_WIDTH = 24;
  localparam int CNT_WIDTH = 8;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    FLUSH = 2'd1,
    HOLD  = 2'd2
  } state_e;

endpackage

// File: rtl/mac_accumulator_if.sv
// mac_accumulator_if: operand input and result output handshakes.
// master drives beats and out_ready; slave is the MAC stage.
interface mac_accumulator_if
  import mac_pkg::*;
#(
  parameter int WIDTH     = mac_pkg::WIDTH,
  parameter int ACC_WIDTH = mac_pkg::ACC_WIDTH,
  parameter int CNT_WIDTH = mac_pkg::CNT_WIDTH
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     in_a;
  logic [WIDTH-1:0]     in_b;
  logic                 in_last;
  logic                 out_valid;
  logic                 out_ready;
  logic [ACC_WIDTH-1:0] out_sum;
  logic [CNT_WIDTH-1:0] out_count;
  logic                 out_ovf;

  modport master (
    output in_valid, in_a, in_b, in_last, out_ready,
    input  in_ready, out_valid, out_sum, out_count, out_ovf
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, out_ready,
    output in_ready, out_valid, out_sum, out_count, out_ovf
  );

endinterface

// File: rtl/mac_accumulator_mult.sv
// Multiplier8Bit_Unsigned: combinational 8x8 -> 16 unsigned multiply.
// Ports: A, B operands; P product; O overflow (never set at 16 bits).
module Multiplier8Bit_Unsigned (
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic [15:0] P,
  output logic        O
);

  assign P = A * B;
  assign O = 1'b0;

endmodule

// File: rtl/mac_accumulator.sv
// mac_accumulator: registered-product dot-product accumulator.
// Ports: clk, rst_n (async low), soft_clr (sync), bus (slave).
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int WIDTH     = mac_pkg::WIDTH,
  parameter int ACC_WIDTH = mac_pkg::ACC_WIDTH,
  parameter int CNT_WIDTH = mac_pkg::CNT_WIDTH
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               soft_clr,
  mac_accumulator_if.slave   bus
);

  localparam int PW = 2 * WIDTH;

  state_e               state_q, state_d;
  logic                 s1_valid_q, s1_valid_d;
  logic                 s1_last_q, s1_last_d;
  logic [PW-1:0]        p_q, p_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic                 ovf_q, ovf_d;

  logic [PW-1:0]        mul_p;
  logic                 mul_unused_o;
  logic                 accept;
  logic [ACC_WIDTH:0]   sum_ext;

  Multiplier8Bit_Unsigned u_mul (
    .A (bus.in_a),
    .B (bus.in_b),
    .P (mul_p),
    .O (mul_unused_o)
  );

  assign bus.in_ready  = (state_q == ACCUM);
  assign bus.out_valid = (state_q == HOLD);
  assign bus.out_sum   = acc_q;
  assign bus.out_count = cnt_q;
  assign bus.out_ovf   = ovf_q;

  assign accept  = bus.in_valid && bus.in_ready;
  // extra top bit captures the carry out of the accumulator
  assign sum_ext = {1'b0, acc_q} + (ACC_WIDTH + 1)'(p_q);

  always_comb begin
    state_d    = state_q;
    s1_valid_d = accept;
    s1_last_d  = accept && bus.in_last;
    p_d        = accept ? mul_p : p_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;

    if (s1_valid_q) begin
      acc_d = sum_ext[ACC_WIDTH-1:0];
      ovf_d = ovf_q | sum_ext[ACC_WIDTH];
      cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
    end

    unique case (state_q)
      ACCUM: begin
        if (accept && bus.in_last) state_d = FLUSH;
      end
      FLUSH: begin
        if (s1_valid_q && s1_last_q) state_d = HOLD;
      end
      HOLD: begin
        if (bus.out_ready) begin
          state_d = ACCUM;
          acc_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
        end
      end
      default: state_d = ACCUM;
    endcase

    if (soft_clr) begin
      state_d    = ACCUM;
      s1_valid_d = 1'b0;
      s1_last_d  = 1'b0;
      acc_d      = '0;
      cnt_d      = '0;
      ovf_d      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      s1_valid_q <= 1'b0;
      s1_last_q  <= 1'b0;
      p_q        <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      s1_valid_q <= s1_valid_d;
      s1_last_q  <= s1_last_d;
      p_q        <= p_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
    end
  end

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed checks of the MAC stage.
// Hand-computed sums, latency, backpressure, clears and reset.
module tb_mac_accumulator;

  logic clk;
  logic rst_n;
  logic soft_clr;

  int n_checks;
  int n_err;

  mac_accumulator_if #(
    .WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(8)
  ) bus ();

  mac_accumulator #(
    .WIDTH(8), .ACC_WIDTH(24), .CNT_WIDTH(8)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .soft_clr (soft_clr),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic [7:0] a,
                      input logic [7:0] b,
                      input logic last);
    bus.in_valid = 1'b1;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_last  = last;
    #1;
    chk("in_ready_beat", 32'(bus.in_ready), 32'd1);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic consume();
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    chk("consume_valid", 32'(bus.out_valid), 32'd0);
    chk("consume_sum", 32'(bus.out_sum), 32'd0);
    chk("consume_count", 32'(bus.out_count), 32'd0);
    chk("consume_ovf", 32'(bus.out_ovf), 32'd0);
    chk("consume_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic chk_res(input string tag,
                         input logic [31:0] sum,
                         input logic [31:0] cnt,
                         input logic ovf);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(bus.out_sum), sum);
    chk({tag, "_count"}, 32'(bus.out_count), cnt);
    chk({tag, "_ovf"}, 32'(bus.out_ovf), 32'(ovf));
  endtask

  initial begin
    n_checks      = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    soft_clr      = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.out_ready = 1'b0;

    tick();
    tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", 32'(bus.out_sum), 32'd0);
    chk("rst_count", 32'(bus.out_count), 32'd0);
    chk("rst_ovf", 32'(bus.out_ovf), 32'd0);
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // single beat, 2-cycle latency
    beat(8'd15, 8'd10, 1'b1);
    chk("single_t1_ready", 32'(bus.in_ready), 32'd0);
    chk("single_t1_valid", 32'(bus.out_valid), 32'd0);
    tick();
    chk("single_t2_ready", 32'(bus.in_ready), 32'd0);
    chk_res("single", 32'd150, 32'd1, 1'b0);
    consume();

    // three back-to-back beats
    beat(8'd200, 8'd63, 1'b0);
    beat(8'd169, 8'd38, 1'b0);
    beat(8'd15, 8'd10, 1'b1);
    tick();
    tick();
    chk_res("three", 32'd19172, 32'd3, 1'b0);
    consume();

    // 259 beats: wraps and saturates count
    for (int i = 0; i < 258; i++) beat(8'd255, 8'd255, 1'b0);
    beat(8'd255, 8'd255, 1'b1);
    tick();
    tick();
    chk_res("ovf259", 32'd64259, 32'd255, 1'b1);
    consume();

    // 258 beats: just below the wrap
    for (int i = 0; i < 257; i++) beat(8'd255, 8'd255, 1'b0);
    beat(8'd255, 8'd255, 1'b1);
    tick();
    tick();
    chk_res("sat258", 32'd16776450, 32'd255, 1'b0);
    consume();

    // backpressure with beats offered while holding
    beat(8'd30, 8'd46, 1'b1);
    tick();
    chk_res("bp", 32'd1380, 32'd1, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_a     = 8'd1;
    bus.in_b     = 8'd70;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_hold_sum", 32'(bus.out_sum), 32'd1380);
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
    consume();
    beat(8'd1, 8'd70, 1'b1);
    tick();
    tick();
    chk_res("bp_next", 32'd70, 32'd1, 1'b0);
    consume();

    // soft_clr mid-vector, beat in same cycle dropped
    beat(8'd192, 8'd150, 1'b0);
    beat(8'd62, 8'd43, 1'b0);
    soft_clr     = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_a     = 8'd9;
    bus.in_b     = 8'd9;
    tick();
    soft_clr     = 1'b0;
    bus.in_valid = 1'b0;
    chk("clr_sum", 32'(bus.out_sum), 32'd0);
    chk("clr_count", 32'(bus.out_count), 32'd0);
    tick();
    chk("clr_sum2", 32'(bus.out_sum), 32'd0);
    beat(8'd1, 8'd1, 1'b1);
    tick();
    tick();
    chk_res("clr", 32'd1, 32'd1, 1'b0);
    consume();

    // async reset while holding a result
    beat(8'd50, 8'd50, 1'b1);
    tick();
    tick();
    chk_res("pre_rst", 32'd2500, 32'd1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 32'(bus.out_valid), 32'd0);
    chk("arst_sum", 32'(bus.out_sum), 32'd0);
    chk("arst_count", 32'(bus.out_count), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    beat(8'd136, 8'd255, 1'b1);
    tick();
    tick();
    chk_res("post_rst", 32'd34680, 32'd1, 1'b0);
    consume();

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_err);
    $finish;
  end

endmodule
